// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic array: default geometry, feeder state
// encoding and the drain length needed for the last products to reach the far corner.
package systolic_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH = 8;
  localparam int unsigned DEFAULT_N          = 4;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    FLUSH,
    DONE
  } feeder_state_e;

  // Zero cycles needed after the last vector so lane N-1 data crosses the whole array.
  function automatic int unsigned flush_len(input int unsigned n);
    return 2 * n - 1;
  endfunction

endpackage

// File: rtl/skew_delay_line.sv
// DEPTH-stage shift register used as one skew lane of the systolic feeder;
// the last stage is the registered edge output.
module skew_delay_line #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] sample,
  output logic [DATA_WIDTH-1:0] delayed
);

  logic [DEPTH-1:0][DATA_WIDTH-1:0] stages_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stages_q <= '0;
    end else begin
      stages_q[0] <= sample;
      for (int k = 1; k < DEPTH; k++) begin
        stages_q[k] <= stages_q[k-1];
      end
    end
  end

  assign delayed = stages_q[DEPTH-1];

endmodule

// File: rtl/systolic_skew_feeder.sv
// Skews A/B vector pairs onto the systolic array edges and drains with zeros.
// Optional stall counter enabled by SKEW_FEEDER_STALL_COUNT_EN.
module systolic_skew_feeder
  import systolic_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned N          = DEFAULT_N,
  parameter int unsigned K_WIDTH    = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic [K_WIDTH-1:0]      k_len,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [N*DATA_WIDTH-1:0] a_vec,
  input  logic [N*DATA_WIDTH-1:0] b_vec,
  output logic [N*DATA_WIDTH-1:0] a_edge,
  output logic [N*DATA_WIDTH-1:0] b_edge,
  output logic                    busy,
  output logic                    done
`ifdef SKEW_FEEDER_STALL_COUNT_EN
  ,
  output logic [15:0]             stall_count
`endif
);

  localparam int unsigned FlushLen  = flush_len(N);
  localparam int unsigned FlushCntW = $clog2(FlushLen + 1);
  localparam logic [FlushCntW-1:0] FlushLast = FlushCntW'(FlushLen - 1);

  feeder_state_e state_q, state_d;

  logic [K_WIDTH-1:0]   k_len_q;
  logic [K_WIDTH-1:0]   acc_cnt_q;
  logic [FlushCntW-1:0] flush_cnt_q;

  logic accept;
  logic last_accept;
  logic start_taken;

  logic [N*DATA_WIDTH-1:0] a_feed;
  logic [N*DATA_WIDTH-1:0] b_feed;

  assign accept      = in_valid && in_ready;
  assign last_accept = (acc_cnt_q + K_WIDTH'(1)) == k_len_q;
  assign start_taken = (state_q == IDLE) && start;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = (k_len == '0) ? DONE : STREAM;
        end
      end
      STREAM: begin
        if (accept && last_accept) begin
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        if (flush_cnt_q == FlushLast) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state_q)
      STREAM: begin
        in_ready = 1'b1;
        busy     = 1'b1;
      end
      FLUSH:   busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      k_len_q     <= '0;
      acc_cnt_q   <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (start_taken) begin
        k_len_q   <= k_len;
        acc_cnt_q <= '0;
      end else if (accept) begin
        acc_cnt_q <= acc_cnt_q + K_WIDTH'(1);
      end
      if (state_q == FLUSH) begin
        flush_cnt_q <= flush_cnt_q + 1'b1;
      end else begin
        flush_cnt_q <= '0;
      end
    end
  end

`ifdef SKEW_FEEDER_STALL_COUNT_EN
  logic [15:0] stall_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_q <= '0;
    end else if (start_taken) begin
      stall_q <= '0;
    end else if ((state_q == STREAM) && !in_valid && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_count = stall_q;
`endif

  // Bubbles and drain cycles inject zeros so MAC alignment is preserved.
  assign a_feed = accept ? a_vec : '0;
  assign b_feed = accept ? b_vec : '0;

  for (genvar i = 0; i < N; i++) begin : g_lane
    logic [DATA_WIDTH-1:0] a_out;
    logic [DATA_WIDTH-1:0] b_out;

    skew_delay_line #(
      .DATA_WIDTH(DATA_WIDTH),
      .DEPTH     (i + 1)
    ) u_a_line (
      .clk    (clk),
      .reset_n(reset_n),
      .sample (a_feed[i*DATA_WIDTH +: DATA_WIDTH]),
      .delayed(a_out)
    );

    skew_delay_line #(
      .DATA_WIDTH(DATA_WIDTH),
      .DEPTH     (i + 1)
    ) u_b_line (
      .clk    (clk),
      .reset_n(reset_n),
      .sample (b_feed[i*DATA_WIDTH +: DATA_WIDTH]),
      .delayed(b_out)
    );

    assign a_edge[i*DATA_WIDTH +: DATA_WIDTH] = a_out;
    assign b_edge[i*DATA_WIDTH +: DATA_WIDTH] = b_out;
  end

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Directed bench for systolic_skew_feeder with a per-cycle scoreboard of skewed lane
// values and done pulses; covers the optional stall counter when SKEW_FEEDER_STALL_COUNT_EN is set.
module tb_systolic_skew_feeder;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int W  = N * DW;
  localparam int FLUSH_LEN = 2 * N - 1;

  typedef struct {
    int           cyc;
    int           lane;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
  } lane_exp_t;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic          start = 1'b0;
  logic [15:0]   k_len = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  a_vec = '0;
  logic [W-1:0]  b_vec = '0;
  logic [W-1:0]  a_edge;
  logic [W-1:0]  b_edge;
  logic          busy;
  logic          done;
`ifdef SKEW_FEEDER_STALL_COUNT_EN
  logic [15:0]   stall_count;
`endif

  int        cyc = 0;
  int        checks = 0;
  int        errors = 0;
  bit        mon_en = 1'b0;
  lane_exp_t sb[$];
  int        done_q[$];

  systolic_skew_feeder #(
    .DATA_WIDTH(DW),
    .N         (N),
    .K_WIDTH   (16)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .k_len   (k_len),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .a_vec   (a_vec),
    .b_vec   (b_vec),
    .a_edge  (a_edge),
    .b_edge  (b_edge),
    .busy    (busy),
    .done    (done)
`ifdef SKEW_FEEDER_STALL_COUNT_EN
    ,
    .stall_count(stall_count)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Scoreboard: lane i of a vector accepted at edge e shows up after edge e+i.
  always @(negedge clk) begin
    logic [W-1:0] ea;
    logic [W-1:0] eb;
    logic         ed;
    if (mon_en) begin
      ea = '0;
      eb = '0;
      for (int j = sb.size() - 1; j >= 0; j--) begin
        if (sb[j].cyc == cyc) begin
          ea[sb[j].lane*DW +: DW] = sb[j].a;
          eb[sb[j].lane*DW +: DW] = sb[j].b;
          sb.delete(j);
        end
      end
      ed = 1'b0;
      if (done_q.size() > 0 && done_q[0] == cyc) begin
        ed = 1'b1;
        void'(done_q.pop_front());
      end
      chk("a_edge", 64'(a_edge), 64'(ea));
      chk("b_edge", 64'(b_edge), 64'(eb));
      chk("done", 64'(done), 64'(ed));
    end
  end

  task automatic step(input logic st, input logic [15:0] k, input logic v,
                      input logic [W-1:0] a, input logic [W-1:0] b,
                      input bit acc, input bit last);
    int e;
    @(negedge clk);
    e = cyc + 1;
    start = st;
    k_len = k;
    in_valid = v;
    a_vec = a;
    b_vec = b;
    if (acc) begin
      for (int i = 0; i < N; i++) begin
        sb.push_back('{cyc: e + i, lane: i, a: a[i*DW +: DW], b: b[i*DW +: DW]});
      end
    end
    if (last) done_q.push_back(e + FLUSH_LEN);
  endtask

  task automatic start_job(input logic [15:0] k);
    step(1'b1, k, 1'b0, '0, '0, 1'b0, 1'b0);
    if (k == 0) done_q.push_back(cyc + 1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "_a_edge"}, 64'(a_edge), 64'd0);
    chk({tag, "_b_edge"}, 64'(b_edge), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_in_ready"}, 64'(in_ready), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    // Power-on reset, checked before the first clock edge.
    #1 reset_n = 1'b0;
    #1 check_quiet("por");
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    mon_en = 1'b1;
    idle(2);

    // Single vector pair.
    start_job(16'd1);
    step(1'b0, '0, 1'b1, 32'h04030201, 32'h08070605, 1'b1, 1'b1);
    chk("single_in_ready_stream", 64'(in_ready), 64'd1);
    chk("single_busy_stream", 64'(busy), 64'd1);
    step(1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b0);
    chk("single_in_ready_flush", 64'(in_ready), 64'd0);
    chk("single_busy_flush", 64'(busy), 64'd1);
    idle(10);
    chk("single_busy_after", 64'(busy), 64'd0);

    // One-cycle bubble between two vectors.
    start_job(16'd2);
    step(1'b0, '0, 1'b1, 32'h01010101, 32'h01010101, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 32'hDEADBEEF, 32'hCAFEF00D, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 32'h02020202, 32'h02020202, 1'b1, 1'b1);
    idle(12);
`ifdef SKEW_FEEDER_STALL_COUNT_EN
    chk("stall_count_bubble", 64'(stall_count), 64'd1);
`endif

    // Zero-length job: done next cycle, never busy.
    start_job(16'd0);
    step(1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b0);
    chk("k0_busy_done_cycle", 64'(busy), 64'd0);
    step(1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b0);
    chk("k0_busy_after", 64'(busy), 64'd0);
    idle(2);

    // Start pulse during STREAM must not restart the count.
    start_job(16'd3);
    step(1'b0, '0, 1'b1, 32'h11223344, 32'h55667788, 1'b1, 1'b0);
    step(1'b1, 16'd7, 1'b1, 32'h99AABBCC, 32'hDDEEFF00, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 32'h0F1E2D3C, 32'h4B5A6978, 1'b1, 1'b1);
    idle(12);

    // Signed extremes pass bit-exact.
    start_job(16'd1);
    step(1'b0, '0, 1'b1, 32'h00FF7F80, 32'h807FFF00, 1'b1, 1'b1);
    idle(12);

    // Reset in the middle of STREAM after 2 of 5 accepts.
    start_job(16'd5);
    step(1'b0, '0, 1'b1, 32'hA1A2A3A4, 32'hB1B2B3B4, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 32'hC1C2C3C4, 32'hD1D2D3D4, 1'b1, 1'b0);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1 check_quiet("midrst");
    sb.delete();
    done_q.delete();
    @(negedge clk);
    reset_n = 1'b1;
    idle(12);

    // Fresh single-vector job after the aborted one.
    start_job(16'd1);
    step(1'b0, '0, 1'b1, 32'h04030201, 32'h08070605, 1'b1, 1'b1);
    idle(12);

    chk("sb_drained", 64'(sb.size()), 64'd0);
    chk("done_drained", 64'(done_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
